// File: rtl/mandel_pkg.sv
// mandel_pkg: shared state type and coordinate/depth widths for the Mandelbrot
// frame scheduler.
package mandel_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
   localparam int COORD_X_W = 10;
   localparam int COORD_Y_W = 9;
   localparam int DEPTH_W   = 10;
   localparam int ITER_W    = 10;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position that wraps at end of line and end of frame.
module raster_counter
   import mandel_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 inc,
   output logic [COORD_X_W-1:0] x,
   output logic [COORD_Y_W-1:0] y
);
   logic [COORD_X_W-1:0] x_q, x_d;
   logic [COORD_Y_W-1:0] y_q, y_d;
   logic                 x_last, y_last;

   assign x_last = x_q == COORD_X_W'(H_RES - 1);
   assign y_last = y_q == COORD_Y_W'(V_RES - 1);
   assign x      = x_q;
   assign y      = y_q;

   always_comb begin
      x_d = clr ? '0 : inc ? (x_last ? '0 : x_q + 1'b1) : x_q;
      y_d = clr ? '0 : inc && x_last ? (y_last ? '0 : y_q + 1'b1) : y_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
endmodule

// File: rtl/engine_scheduler.sv
// engine_scheduler: walks the pixel raster, hands pixels round-robin to depth engines
// and re-serialises their results into a raster-ordered valid/ready pixel stream.
module engine_scheduler
   import mandel_pkg::*;
#(
   parameter int N_ENGINES   = 4,
   parameter int WORD_LENGTH = 32,
   parameter int FRAC        = 28,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480
) (
   input  logic                             sysclk,
   input  logic                             reset_n,
   input  logic                             frame_start,
   input  logic [WORD_LENGTH-1:0]           re_base,
   input  logic [WORD_LENGTH-1:0]           im_base,
   input  logic [WORD_LENGTH-1:0]           step,
   input  logic [ITER_W-1:0]                max_iter,
   output logic [N_ENGINES-1:0]             eng_start,
   output logic [N_ENGINES*WORD_LENGTH-1:0] eng_re_c,
   output logic [N_ENGINES*WORD_LENGTH-1:0] eng_im_c,
   output logic [ITER_W-1:0]                eng_max_iter,
   input  logic [N_ENGINES-1:0]             eng_done,
   input  logic [N_ENGINES*DEPTH_W-1:0]     eng_depth,
   output logic                             pix_valid,
   input  logic                             pix_ready,
   output logic [COORD_X_W-1:0]             pix_x,
   output logic [COORD_Y_W-1:0]             pix_y,
   output logic [DEPTH_W-1:0]               pix_depth,
   output logic                             pix_sof,
   output logic                             pix_eol,
   output logic                             busy,
   output logic                             frame_done
);
   localparam int PTR_W = N_ENGINES > 1 ? $clog2(N_ENGINES) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_ENGINES - 1);

   typedef logic [WORD_LENGTH-1:0] word_t;

   if (FRAC >= WORD_LENGTH) begin : g_frac_chk
      $error("FRAC must be smaller than WORD_LENGTH");
   end

   sched_state_t                      state_q, state_d;
   word_t                             re_base_q, re_base_d, im_base_q, im_base_d;
   word_t                             step_q, step_d, cur_re_q, cur_re_d, cur_im_q, cur_im_d;
   logic [ITER_W-1:0]                 max_iter_q, max_iter_d;
   logic [PTR_W-1:0]                  disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
   logic [N_ENGINES-1:0]              start_q, start_d, busy_q, busy_d, full_q, full_d, done_hit;
   word_t [N_ENGINES-1:0]             re_c_q, re_c_d, im_c_q, im_c_d;
   logic [N_ENGINES-1:0][DEPTH_W-1:0] slot_q, slot_d, depth_in;
   logic                              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d;
   logic                              pix_eol_q, pix_eol_d, pix_last_q, pix_last_d;
   logic                              frame_done_q, frame_done_d;
   logic [COORD_X_W-1:0]              pix_x_q, pix_x_d, disp_x, ret_x;
   logic [COORD_Y_W-1:0]              pix_y_q, pix_y_d, disp_y, ret_y;
   logic [DEPTH_W-1:0]                pix_depth_q, pix_depth_d;
   logic                              frame_go, disp_go, ret_go, last_acc;
   logic                              disp_x_last, disp_y_last, ret_x_last, ret_y_last;

   raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_disp_cnt (
      .clk(sysclk), .rst_n(reset_n), .clr(frame_go), .inc(disp_go), .x(disp_x), .y(disp_y)
   );

   raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_ret_cnt (
      .clk(sysclk), .rst_n(reset_n), .clr(frame_go), .inc(ret_go), .x(ret_x), .y(ret_y)
   );

   assign disp_x_last = disp_x == COORD_X_W'(H_RES - 1);
   assign disp_y_last = disp_y == COORD_Y_W'(V_RES - 1);
   assign ret_x_last  = ret_x == COORD_X_W'(H_RES - 1);
   assign ret_y_last  = ret_y == COORD_Y_W'(V_RES - 1);
   assign depth_in    = eng_depth;
   assign done_hit    = busy_q & eng_done;
   assign frame_go    = state_q == IDLE && frame_start;
   // An engine whose start pulse is still in flight is not yet marked busy, so it is excluded too.
   assign disp_go     = state_q == RUN && !(start_q[disp_ptr_q] || busy_q[disp_ptr_q] || full_q[disp_ptr_q]);
   assign ret_go      = full_q[ret_ptr_q] && (!pix_valid_q || pix_ready);
   assign last_acc    = pix_valid_q && pix_ready && pix_last_q;

   always_comb begin
      state_d      = state_q;
      re_base_d    = re_base_q;
      im_base_d    = im_base_q;
      step_d       = step_q;
      max_iter_d   = max_iter_q;
      cur_re_d     = cur_re_q;
      cur_im_d     = cur_im_q;
      disp_ptr_d   = disp_ptr_q;
      ret_ptr_d    = ret_ptr_q;
      re_c_d       = re_c_q;
      im_c_d       = im_c_q;
      slot_d       = slot_q;
      start_d      = '0;
      busy_d       = (busy_q & ~done_hit) | start_q;
      full_d       = full_q | done_hit;
      pix_valid_d  = pix_valid_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_depth_d  = pix_depth_q;
      pix_sof_d    = pix_sof_q;
      pix_eol_d    = pix_eol_q;
      pix_last_d   = pix_last_q;
      frame_done_d = state_q == DRAIN && last_acc;
      for (int k = 0; k < N_ENGINES; k++)
         slot_d[k] = done_hit[k] ? depth_in[k] : slot_q[k];
      if (frame_go) begin
         state_d    = RUN;
         re_base_d  = re_base;
         im_base_d  = im_base;
         step_d     = step;
         max_iter_d = max_iter;
         cur_re_d   = re_base;
         cur_im_d   = im_base;
         disp_ptr_d = '0;
         ret_ptr_d  = '0;
      end
      if (disp_go) begin
         start_d[disp_ptr_q] = 1'b1;
         re_c_d[disp_ptr_q]  = cur_re_q;
         im_c_d[disp_ptr_q]  = cur_im_q;
         cur_re_d            = disp_x_last ? re_base_q : cur_re_q + step_q;
         cur_im_d            = disp_x_last ? cur_im_q - step_q : cur_im_q;
         disp_ptr_d          = disp_ptr_q == PTR_LAST ? '0 : disp_ptr_q + 1'b1;
         state_d             = disp_x_last && disp_y_last ? DRAIN : state_d;
      end
      if (frame_done_d)
         state_d = IDLE;
      if (ret_go) begin
         full_d[ret_ptr_q] = 1'b0;
         ret_ptr_d         = ret_ptr_q == PTR_LAST ? '0 : ret_ptr_q + 1'b1;
         pix_valid_d       = 1'b1;
         pix_x_d           = ret_x;
         pix_y_d           = ret_y;
         pix_depth_d       = slot_q[ret_ptr_q];
         pix_sof_d         = ret_x == '0 && ret_y == '0;
         pix_eol_d         = ret_x_last;
         pix_last_d        = ret_x_last && ret_y_last;
      end else if (pix_ready) begin
         pix_valid_d = 1'b0;
      end
   end

   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) begin
         state_q      <= IDLE;
         re_base_q    <= '0;
         im_base_q    <= '0;
         step_q       <= '0;
         max_iter_q   <= '0;
         cur_re_q     <= '0;
         cur_im_q     <= '0;
         disp_ptr_q   <= '0;
         ret_ptr_q    <= '0;
         start_q      <= '0;
         busy_q       <= '0;
         full_q       <= '0;
         re_c_q       <= '0;
         im_c_q       <= '0;
         slot_q       <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_depth_q  <= '0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         pix_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         re_base_q    <= re_base_d;
         im_base_q    <= im_base_d;
         step_q       <= step_d;
         max_iter_q   <= max_iter_d;
         cur_re_q     <= cur_re_d;
         cur_im_q     <= cur_im_d;
         disp_ptr_q   <= disp_ptr_d;
         ret_ptr_q    <= ret_ptr_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         full_q       <= full_d;
         re_c_q       <= re_c_d;
         im_c_q       <= im_c_d;
         slot_q       <= slot_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_depth_q  <= pix_depth_d;
         pix_sof_q    <= pix_sof_d;
         pix_eol_q    <= pix_eol_d;
         pix_last_q   <= pix_last_d;
         frame_done_q <= frame_done_d;
      end

   assign eng_start    = start_q;
   assign eng_re_c     = re_c_q;
   assign eng_im_c     = im_c_q;
   assign eng_max_iter = max_iter_q;
   assign pix_valid    = pix_valid_q;
   assign pix_x        = pix_x_q;
   assign pix_y        = pix_y_q;
   assign pix_depth    = pix_depth_q;
   assign pix_sof      = pix_sof_q;
   assign pix_eol      = pix_eol_q;
   assign busy         = state_q != IDLE;
   assign frame_done   = frame_done_q;
endmodule
